// File: rtl/phase_error_monitor.sv
// phase_error_monitor: live/average/min/max phase-error statistics with lock detection and loss-of-lock tracking
module phase_error_monitor #(
   parameter int ERR_W       = 8,
   parameter int AVG_LOG2    = 4,
   parameter int LOCK_THRESH = 2,
   parameter int LOCK_COUNT  = 32,
   parameter int CNT_W       = 8
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    enable_i,
   input  logic                    sample_i,
   input  logic signed [ERR_W-1:0] error_i,
   input  logic                    clear_i,
   input  logic [1:0]              mode_i,
   output logic signed [ERR_W-1:0] value_o,
   output logic                    valid_o,
   output logic                    locked_o,
   output logic                    lock_lost_o,
   output logic [CNT_W-1:0]        loss_count_o
);
   localparam int SW = ERR_W + AVG_LOG2;
   localparam int RW = $clog2(LOCK_COUNT + 1);
   localparam int WW = AVG_LOG2 + 1;
   localparam logic [ERR_W:0] THR = (ERR_W+1)'(LOCK_THRESH);
   typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;
   state_t state_q, state_d;
   logic signed [ERR_W-1:0] live_q, live_d, avg_q, avg_d, min_q, min_d, max_q, max_d;
   logic live_v_q, live_v_d, avg_v_q, avg_v_d, mm_v_q, mm_v_d, lost_q, lost_d;
   logic signed [SW-1:0] sum_q, sum_d, sum_nx;
   logic [WW-1:0] win_q, win_d;
   logic [RW-1:0] run_q, run_d;
   logic [CNT_W-1:0] loss_q, loss_d;
   logic [ERR_W:0] err_x, err_abs;
   logic acc, win_full, in_band;
   assign acc = sample_i & enable_i & ~clear_i;
   assign sum_nx = sum_q + {{AVG_LOG2{error_i[ERR_W-1]}}, error_i};
   assign win_full = win_q == WW'(2**AVG_LOG2 - 1);
   // one extra bit so the most negative error has a representable magnitude
   assign err_x = {error_i[ERR_W-1], error_i};
   assign err_abs = error_i[ERR_W-1] ? ~err_x + 1'b1 : err_x;
   assign in_band = err_abs <= THR;
   always_comb begin
      live_d = live_q;
      live_v_d = live_v_q;
      avg_d = avg_q;
      avg_v_d = avg_v_q;
      min_d = min_q;
      max_d = max_q;
      mm_v_d = mm_v_q;
      sum_d = sum_q;
      win_d = win_q;
      if (clear_i) begin
         live_d = '0;
         live_v_d = 1'b0;
         avg_d = '0;
         avg_v_d = 1'b0;
         min_d = '0;
         max_d = '0;
         mm_v_d = 1'b0;
         sum_d = '0;
         win_d = '0;
      end else if (acc) begin
         live_d = error_i;
         live_v_d = 1'b1;
         sum_d = win_full ? '0 : sum_nx;
         win_d = win_full ? '0 : win_q + 1'b1;
         avg_d = win_full ? sum_nx[SW-1:AVG_LOG2] : avg_q;
         avg_v_d = avg_v_q | win_full;
         min_d = (!mm_v_q || error_i < min_q) ? error_i : min_q;
         max_d = (!mm_v_q || error_i > max_q) ? error_i : max_q;
         mm_v_d = 1'b1;
      end
   end
   always_comb begin
      state_d = state_q;
      run_d = run_q;
      lost_d = lost_q;
      loss_d = loss_q;
      if (clear_i) begin
         lost_d = 1'b0;
         loss_d = '0;
      end else if (acc) begin
         case (state_q)
            UNLOCKED: if (in_band) begin
               run_d = RW'(1);
               state_d = (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;
            end
            ACQUIRE: if (in_band) begin
               run_d = run_q + 1'b1;
               state_d = (run_q + 1'b1 == RW'(LOCK_COUNT)) ? LOCKED : ACQUIRE;
            end else begin
               run_d = '0;
               state_d = UNLOCKED;
            end
            LOCKED: if (!in_band) begin
               run_d = '0;
               state_d = UNLOCKED;
               lost_d = 1'b1;
               loss_d = &loss_q ? loss_q : loss_q + 1'b1;
            end
            default: state_d = UNLOCKED;
         endcase
      end
   end
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= UNLOCKED;
         live_q <= '0;
         live_v_q <= 1'b0;
         avg_q <= '0;
         avg_v_q <= 1'b0;
         min_q <= '0;
         max_q <= '0;
         mm_v_q <= 1'b0;
         sum_q <= '0;
         win_q <= '0;
         run_q <= '0;
         lost_q <= 1'b0;
         loss_q <= '0;
      end else begin
         state_q <= state_d;
         live_q <= live_d;
         live_v_q <= live_v_d;
         avg_q <= avg_d;
         avg_v_q <= avg_v_d;
         min_q <= min_d;
         max_q <= max_d;
         mm_v_q <= mm_v_d;
         sum_q <= sum_d;
         win_q <= win_d;
         run_q <= run_d;
         lost_q <= lost_d;
         loss_q <= loss_d;
      end
   end
   assign value_o = (mode_i == 2'd0) ? live_q : (mode_i == 2'd1) ? avg_q : (mode_i == 2'd2) ? min_q : max_q;
   assign valid_o = (mode_i == 2'd0) ? live_v_q : (mode_i == 2'd1) ? avg_v_q : mm_v_q;
   assign locked_o = state_q == LOCKED;
   assign lock_lost_o = lost_q;
   assign loss_count_o = loss_q;
endmodule
